// File: rtl/ym2610_pcm_pkg.sv
// ym2610_pcm_pkg: shared definitions for the YM2610 PCM fetch sequencer.
//   - board mux select codes for address read-back and data write-back
//   - sequencer FSM state enum and channel enum
//   - helpers mapping (channel, nybble index) to a mux select code
package ym2610_pcm_pkg;

    // Address read-back selects, ADPCM-A (RAD/RA bus)
    localparam logic [2:0] SEL_RAD_LO  = 3'b000;
    localparam logic [2:0] SEL_RAD_HI  = 3'b100;
    localparam logic [2:0] SEL_RA_89   = 3'b101;
    localparam logic [2:0] SEL_RA_HI   = 3'b001;
    // Address read-back selects, ADPCM-B (PAD/PA bus)
    localparam logic [2:0] SEL_PAD_LO  = 3'b010;
    localparam logic [2:0] SEL_PAD_HI  = 3'b110;
    localparam logic [2:0] SEL_PA_HI   = 3'b011;
    // Data write-back selects into the PCM holding latches
    localparam logic [2:0] SEL_WR_LO   = 3'b001;
    localparam logic [2:0] SEL_WR_HI_A = 3'b010;
    localparam logic [2:0] SEL_WR_HI_B = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_REQ     = 3'd2,
        ST_WB_TURN = 3'd3,
        ST_WB_LO   = 3'd4,
        ST_WB_HI   = 3'd5,
        ST_WB_LOAD = 3'd6,
        ST_WB_REL  = 3'd7
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

    // Mux select for nybble idx of an address scan. Channel A's high phase
    // reuses the low-phase sequence and appends SEL_RA_HI as nybble 3.
    function automatic logic [2:0] scan_sel(input ch_t ch, input logic [1:0] idx);
        logic [2:0] s;
        s = SEL_RAD_LO;
        if (ch == CH_A) begin
            case (idx)
                2'd0:    s = SEL_RAD_LO;
                2'd1:    s = SEL_RAD_HI;
                2'd2:    s = SEL_RA_89;
                default: s = SEL_RA_HI;
            endcase
        end else begin
            case (idx)
                2'd0:    s = SEL_PAD_LO;
                2'd1:    s = SEL_PAD_HI;
                default: s = SEL_PA_HI;
            endcase
        end
        return s;
    endfunction

    // Index of the last nybble in a scan: 4 nybbles for A-high, 3 otherwise.
    function automatic logic [1:0] last_idx(input ch_t ch, input logic hi);
        return (ch == CH_A && hi) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/ym2610_mpx_edge.sv
// ym2610_mpx_edge: 2-FF synchroniser plus registered rise/fall detector for
// one asynchronous multiplex strobe (RMPX or PMPX).
//   clk, reset_n : system clock, async active-low reset
//   strobe_in    : raw asynchronous strobe
//   rise, fall   : one-cycle pulses, 3 clocks after the input edge lands
module ym2610_mpx_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_in,
    output logic rise,
    output logic fall
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= strobe_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

endmodule

// File: rtl/ym2610_pcm_fetch.sv
// ym2610_pcm_fetch: reads ADPCM-A/B ROM addresses back through the board mux
// on RMPX/PMPX edges, fetches the byte from a memory port and writes it into
// the board PCM latches as two nybbles.
//   clk, reset_n        : system clock, async active-low reset
//   rmpx_in, pmpx_in    : asynchronous multiplex strobes from the YM2610
//   ym_io_in/out/oe     : 4-bit shared pad (read address / drive data)
//   mux_sel, mux_oe_n   : board mux select and active-low output enable
//   pcm_load            : one-cycle load strobe to the PCM latches
//   rom_req/ch/addr     : fetch request; rom_ack/rom_data complete it
//   overrun             : sticky, a strobe edge hit a still-pending request
//   state_dbg           : current sequencer state
//
// Fetch handshake: rom_req rises with rom_ch/rom_addr and all three hold
// steady until the cycle rom_ack is 1; rom_data is taken in that same cycle.
// rom_ack outside the request state is ignored.
//
// All pad/mux/strobe outputs are registered from the next state, so they
// sit at their reset values during reset and change cleanly with the state.
module ym2610_pcm_fetch
    import ym2610_pcm_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rmpx_in,
    input  logic        pmpx_in,
    input  logic [3:0]  ym_io_in,
    output logic [3:0]  ym_io_out,
    output logic        ym_io_oe,
    output logic [2:0]  mux_sel,
    output logic        mux_oe_n,
    output logic        pcm_load,
    output logic        rom_req,
    output logic        rom_ch,
    output logic [23:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        overrun,
    output logic [2:0]  state_dbg
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(SETTLE - 1);

    // Pending bit positions, highest index = highest priority
    localparam int P_A_HI = 3;
    localparam int P_A_LO = 2;
    localparam int P_B_HI = 1;
    localparam int P_B_LO = 0;

    state_t           state_q, state_d;
    ch_t              ch_q, ch_d;
    logic             hi_q, hi_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       pend_q, pend_set, grant;

    logic [3:0]  ym_io_out_d;
    logic        ym_io_oe_d, mux_oe_n_d, pcm_load_d, rom_req_d, rom_ch_d;
    logic [2:0]  mux_sel_d;
    logic [23:0] rom_addr_d;

    logic a_rise, a_fall, b_rise, b_fall;

    ym2610_mpx_edge u_rmpx_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (rmpx_in),
        .rise      (a_rise),
        .fall      (a_fall)
    );

    ym2610_mpx_edge u_pmpx_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (pmpx_in),
        .rise      (b_rise),
        .fall      (b_fall)
    );

    // Rise = low phase, fall = high phase
    assign pend_set  = {a_fall, a_rise, b_fall, b_rise};
    assign state_dbg = state_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        hi_d     = hi_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_d   = data_q;
        grant    = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (pend_q != 4'b0000) begin
                    state_d = ST_SCAN;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    if (pend_q[P_A_HI]) begin
                        ch_d = CH_A; hi_d = 1'b1; grant[P_A_HI] = 1'b1;
                    end else if (pend_q[P_A_LO]) begin
                        ch_d = CH_A; hi_d = 1'b0; grant[P_A_LO] = 1'b1;
                    end else if (pend_q[P_B_HI]) begin
                        ch_d = CH_B; hi_d = 1'b1; grant[P_B_HI] = 1'b1;
                    end else begin
                        ch_d = CH_B; hi_d = 1'b0; grant[P_B_LO] = 1'b1;
                    end
                end
            end

            ST_SCAN: begin
                if (cnt_q == CNT_SAMPLE) begin
                    if (ch_q == CH_A) begin
                        // At SEL_RA_89 only the two low pad bits carry address
                        case ({hi_q, idx_q})
                            3'b0_00: addr_a_d[3:0]   = ym_io_in;
                            3'b0_01: addr_a_d[7:4]   = ym_io_in;
                            3'b0_10: addr_a_d[9:8]   = ym_io_in[1:0];
                            3'b1_00: addr_a_d[13:10] = ym_io_in;
                            3'b1_01: addr_a_d[17:14] = ym_io_in;
                            3'b1_10: addr_a_d[19:18] = ym_io_in[1:0];
                            3'b1_11: addr_a_d[23:20] = ym_io_in;
                            default: ;
                        endcase
                    end else begin
                        case ({hi_q, idx_q})
                            3'b0_00: addr_b_d[3:0]   = ym_io_in;
                            3'b0_01: addr_b_d[7:4]   = ym_io_in;
                            3'b0_10: addr_b_d[11:8]  = ym_io_in;
                            3'b1_00: addr_b_d[15:12] = ym_io_in;
                            3'b1_01: addr_b_d[19:16] = ym_io_in;
                            3'b1_10: addr_b_d[23:20] = ym_io_in;
                            default: ;
                        endcase
                    end
                    if (idx_q == last_idx(ch_q, hi_q)) begin
                        // Only a completed high phase has a full address
                        state_d = hi_q ? ST_REQ : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_REQ: begin
                if (rom_ack) begin
                    data_d  = rom_data;
                    state_d = ST_WB_TURN;
                end
            end

            ST_WB_TURN: begin
                state_d = ST_WB_LO;
                cnt_d   = '0;
            end

            ST_WB_LO: begin
                if (cnt_q == CNT_HOLD) begin
                    state_d = ST_WB_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WB_HI: begin
                if (cnt_q == CNT_HOLD) begin
                    state_d = ST_WB_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WB_LOAD: state_d = ST_WB_REL;
            ST_WB_REL:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Output decode from the next state. The mux is only enabled in
        // IDLE/SCAN/REQ and the pad only driven in WB_LO/HI/LOAD, with
        // WB_TURN and WB_REL as the dead cycles between them.
        mux_sel_d   = SEL_RAD_LO;
        mux_oe_n_d  = 1'b1;
        ym_io_oe_d  = 1'b0;
        ym_io_out_d = 4'h0;
        pcm_load_d  = 1'b0;
        rom_req_d   = 1'b0;
        rom_ch_d    = rom_ch;
        rom_addr_d  = rom_addr;

        case (state_d)
            ST_IDLE: mux_oe_n_d = 1'b0;
            ST_SCAN: begin
                mux_oe_n_d = 1'b0;
                mux_sel_d  = scan_sel(ch_d, idx_d);
            end
            ST_REQ: begin
                mux_oe_n_d = 1'b0;
                rom_req_d  = 1'b1;
                rom_ch_d   = ch_d;
                rom_addr_d = (ch_d == CH_A) ? addr_a_d : addr_b_d;
            end
            ST_WB_LO: begin
                ym_io_oe_d  = 1'b1;
                mux_sel_d   = SEL_WR_LO;
                ym_io_out_d = data_d[3:0];
            end
            ST_WB_HI, ST_WB_LOAD: begin
                ym_io_oe_d  = 1'b1;
                mux_sel_d   = (ch_d == CH_A) ? SEL_WR_HI_A : SEL_WR_HI_B;
                ym_io_out_d = data_d[7:4];
                pcm_load_d  = (state_d == ST_WB_LOAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= CH_A;
            hi_q      <= 1'b0;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            addr_a_q  <= 24'h0;
            addr_b_q  <= 24'h0;
            data_q    <= 8'h0;
            pend_q    <= 4'b0000;
            overrun   <= 1'b0;
            mux_sel   <= SEL_RAD_LO;
            mux_oe_n  <= 1'b1;
            ym_io_oe  <= 1'b0;
            ym_io_out <= 4'h0;
            pcm_load  <= 1'b0;
            rom_req   <= 1'b0;
            rom_ch    <= 1'b0;
            rom_addr  <= 24'h0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            hi_q      <= hi_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            data_q    <= data_d;
            // A new edge on a bit granted this cycle is a fresh request,
            // not an overrun; an edge on a still-waiting bit is merged.
            pend_q    <= (pend_q & ~grant) | pend_set;
            overrun   <= overrun | (|(pend_set & pend_q & ~grant));
            mux_sel   <= mux_sel_d;
            mux_oe_n  <= mux_oe_n_d;
            ym_io_oe  <= ym_io_oe_d;
            ym_io_out <= ym_io_out_d;
            pcm_load  <= pcm_load_d;
            rom_req   <= rom_req_d;
            rom_ch    <= rom_ch_d;
            rom_addr  <= rom_addr_d;
        end
    end

endmodule

// File: tb/tb_ym2610_pcm_fetch.sv
// tb_ym2610_pcm_fetch: directed bench for ym2610_pcm_fetch with SETTLE = 2.
// A board model presents address nybbles per mux select and latches the
// written nybbles into pcm_r / pcm_p on pcm_load.
module tb_ym2610_pcm_fetch;
    import ym2610_pcm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rmpx_in = 1'b0;
    logic        pmpx_in = 1'b0;
    logic [3:0]  ym_io_in;
    logic [3:0]  ym_io_out;
    logic        ym_io_oe;
    logic [2:0]  mux_sel;
    logic        mux_oe_n;
    logic        pcm_load;
    logic        rom_req;
    logic        rom_ch;
    logic [23:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [7:0]  rom_data = 8'h0;
    logic        overrun;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    ym2610_pcm_fetch #(.SETTLE(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rmpx_in   (rmpx_in),
        .pmpx_in   (pmpx_in),
        .ym_io_in  (ym_io_in),
        .ym_io_out (ym_io_out),
        .ym_io_oe  (ym_io_oe),
        .mux_sel   (mux_sel),
        .mux_oe_n  (mux_oe_n),
        .pcm_load  (pcm_load),
        .rom_req   (rom_req),
        .rom_ch    (rom_ch),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // ---------------- board model ----------------
    logic [3:0] mux_val [8];
    logic [3:0] lo_nyb, hi_a, hi_b;
    logic [7:0] pcm_r, pcm_p;
    int         load_cnt, contention_cnt, cyc, ack_cyc, load_cyc;

    always_comb begin
        ym_io_in = 4'hF;
        if (!mux_oe_n) ym_io_in = mux_val[mux_sel];
    end

    initial begin
        for (int i = 0; i < 8; i++) mux_val[i] = 4'h0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ym_io_oe && mux_oe_n) begin
            case (mux_sel)
                3'b001:  lo_nyb <= ym_io_out;
                3'b010:  hi_a   <= ym_io_out;
                3'b100:  hi_b   <= ym_io_out;
                default: ;
            endcase
        end
        if (rom_req && rom_ack) ack_cyc <= cyc;
        if (pcm_load) begin
            load_cnt <= load_cnt + 1;
            load_cyc <= cyc;
            if (mux_sel == 3'b010) pcm_r <= {ym_io_out, lo_nyb};
            if (mux_sel == 3'b100) pcm_p <= {ym_io_out, lo_nyb};
        end
    end

    initial begin
        load_cnt = 0; contention_cnt = 0; cyc = 0; ack_cyc = 0; load_cyc = 0;
        lo_nyb = 4'h0; hi_a = 4'h0; hi_b = 4'h0; pcm_r = 8'h0; pcm_p = 8'h0;
    end

    always @(negedge clk) begin
        if (ym_io_oe && !mux_oe_n) contention_cnt <= contention_cnt + 1;
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!rom_req && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(rom_req), 64'd1);
    endtask

    task automatic wait_state(input state_t st, input string tag);
        int n = 0;
        while (state_dbg !== st && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(state_dbg), 64'(st));
    endtask

    task automatic ack(input logic [7:0] d);
        rom_ack  = 1'b1;
        rom_data = d;
        @(negedge clk);
        rom_ack  = 1'b0;
        rom_data = 8'h0;
    endtask

    task automatic set_mux(input logic [2:0] sel, input logic [3:0] v);
        mux_val[sel] = v;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values
        wait_cycles(3);
        check("rst_mux_oe_n", 64'(mux_oe_n), 64'd1);
        check("rst_mux_sel",  64'(mux_sel),  64'd0);
        check("rst_ym_io",    64'({ym_io_oe, ym_io_out}), 64'd0);
        check("rst_pcm_load", 64'(pcm_load), 64'd0);
        check("rst_rom",      64'({rom_req, rom_ch, rom_addr}), 64'd0);
        check("rst_overrun",  64'(overrun),  64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_idle_mux_oe_n", 64'(mux_oe_n), 64'd0);

        // Channel A: low phase 0x2A5 (sel 101 carries 0xE, only 2'b10 used)
        set_mux(3'b000, 4'h5); set_mux(3'b100, 4'hA); set_mux(3'b101, 4'hE);
        rmpx_in = 1'b1;
        wait_cycles(20);
        check("a_low_no_req", 64'(rom_req), 64'd0);
        // High phase: a[13:10]=C, a[17:14]=7, a[19:18]=1 (0xD), a[23:20]=9
        set_mux(3'b000, 4'hC); set_mux(3'b100, 4'h7); set_mux(3'b101, 4'hD);
        set_mux(3'b001, 4'h9);
        rmpx_in = 1'b0;
        wait_req("a_req");
        check("a_rom_ch",   64'(rom_ch),   64'd0);
        check("a_rom_addr", 64'(rom_addr), 64'h95F2A5);
        wait_cycles(4);
        check("a_addr_hold", 64'({rom_req, rom_addr}), 64'h1_95F2A5);
        ack(8'hC3);
        wait_state(ST_IDLE, "a_back_idle");
        check("a_lo_nyb",   64'(lo_nyb),   64'h3);
        check("a_hi_nyb",   64'(hi_a),     64'hC);
        check("a_pcm_r",    64'(pcm_r),    64'hC3);
        check("a_load_cnt", 64'(load_cnt), 64'd1);
        check("a_ack_to_load", 64'(load_cyc - ack_cyc), 64'd6);

        // Channel B: 0xABC123
        set_mux(3'b010, 4'h3); set_mux(3'b110, 4'h2); set_mux(3'b011, 4'h1);
        pmpx_in = 1'b1;
        wait_cycles(20);
        set_mux(3'b010, 4'hC); set_mux(3'b110, 4'hB); set_mux(3'b011, 4'hA);
        pmpx_in = 1'b0;
        wait_req("b_req");
        check("b_rom_ch",   64'(rom_ch),   64'd1);
        check("b_rom_addr", 64'(rom_addr), 64'hABC123);
        ack(8'h5E);
        wait_state(ST_IDLE, "b_back_idle");
        check("b_pcm_p",    64'(pcm_p),    64'h5E);
        check("b_hi_sel100", 64'(hi_b),    64'h5);
        check("b_pcm_r_kept", 64'(pcm_r),  64'hC3);
        check("b_load_cnt", 64'(load_cnt), 64'd2);

        // Simultaneous strobes: A = 0x795321, B = 0xBA9876
        set_mux(3'b000, 4'h1); set_mux(3'b100, 4'h2); set_mux(3'b101, 4'h3);
        set_mux(3'b010, 4'h6); set_mux(3'b110, 4'h7); set_mux(3'b011, 4'h8);
        rmpx_in = 1'b1; pmpx_in = 1'b1;
        wait_cycles(40);
        check("sim_rise_no_req", 64'(rom_req), 64'd0);
        set_mux(3'b000, 4'h4); set_mux(3'b100, 4'h5); set_mux(3'b101, 4'h2);
        set_mux(3'b001, 4'h7);
        set_mux(3'b010, 4'h9); set_mux(3'b110, 4'hA); set_mux(3'b011, 4'hB);
        rmpx_in = 1'b0; pmpx_in = 1'b0;
        wait_req("sim_req1");
        check("sim_first_ch",   64'(rom_ch),   64'd0);
        check("sim_first_addr", 64'(rom_addr), 64'h795321);
        ack(8'h11);
        wait_state(ST_REQ, "sim_req2");
        check("sim_a_loaded_before_b", 64'(load_cnt), 64'd3);
        check("sim_second",     64'({rom_req, rom_ch, rom_addr}), 64'h3_BA9876);
        ack(8'h22);
        wait_state(ST_IDLE, "sim_back_idle");
        check("sim_pcm_r",  64'(pcm_r), 64'h11);
        check("sim_pcm_p",  64'(pcm_p), 64'h22);
        check("no_overrun_yet", 64'(overrun), 64'd0);

        // Overrun while a fetch stalls, then reset in WB_HI
        set_mux(3'b000, 4'h0); set_mux(3'b100, 4'h0); set_mux(3'b101, 4'h0);
        set_mux(3'b001, 4'h0);
        rmpx_in = 1'b1;
        wait_cycles(20);
        rmpx_in = 1'b0;
        wait_req("ovr_req");
        rmpx_in = 1'b1; wait_cycles(6);
        rmpx_in = 1'b0; wait_cycles(6);
        rmpx_in = 1'b1; wait_cycles(38);
        check("ovr_still_req", 64'(rom_req), 64'd1);
        check("ovr_set", 64'(overrun), 64'd1);
        ack(8'h77);
        wait_state(ST_WB_HI, "ovr_wb_hi");
        reset_n = 1'b0;
        rmpx_in = 1'b0;
        #1;
        check("rst_mid_overrun", 64'(overrun), 64'd0);
        check("rst_mid_outputs", 64'({mux_oe_n, ym_io_oe, pcm_load, rom_req}), 64'h8);
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(30);
        check("rst_mid_no_load", 64'(load_cnt), 64'd4);
        check("rst_mid_no_req",  64'(rom_req),  64'd0);
        check("rst_mid_idle",    64'(state_dbg), 64'(ST_IDLE));
        check("no_contention",   64'(contention_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
